mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline request port and a single-cycle data memory.
// Optional alignment checking is enabled with the MEM_ACCESS_MISALIGN_CHECK_EN macro.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespError,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        req_accept;
  logic        req_misaligned;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign req_misaligned = (ReqSize == 2'b11) ||
                          ((ReqSize == 2'b01) && ReqAddr[0]) ||
                          ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_accept = ReqValid && (state_q == StIdle);

  // Select the addressed lane and extend it; sizes 10 and 11 both act as word.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) r[31:16] = wdata[15:0];
      else        r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    ReqReady  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    WriteData = 32'h0;
    RespValid = 1'b0;
    unique case (state_q)
      StIdle: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_misaligned) begin
            state_d = StResp;
            rdata_d = 32'h0;
            error_d = 1'b1;
          end else if (!ReqWrite) begin
            state_d = StLoad;
          end else if (ReqSize[1]) begin
            state_d = StStore;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        MemRead = 1'b1;
        rdata_d = load_extend(ReadData, size_q, signed_q, addr_q[1:0]);
        error_d = 1'b0;
        state_d = StResp;
      end
      StStore: begin
        MemWrite  = 1'b1;
        WriteData = wdata_q;
        rdata_d   = 32'h0;
        error_d   = 1'b0;
        state_d   = StResp;
      end
      StRmwRd: begin
        MemRead = 1'b1;
        state_d = StRmwWr;
      end
      StRmwWr: begin
        MemWrite  = 1'b1;
        WriteData = merge_lane(word_q, size_q, addr_q[1:0], wdata_q);
        rdata_d   = 32'h0;
        error_d   = 1'b0;
        state_d   = StResp;
      end
      StResp: begin
        RespValid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address is only driven while a memory access is actually in flight.
  assign Address   = (MemRead || MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign RespRData = rdata_q;
  assign RespError = error_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
    end else begin
      if (req_accept) begin
        size_q   <= ReqSize;
        signed_q <= ReqSigned;
        addr_q   <= ReqAddr;
        wdata_q  <= ReqWData;
      end
      if (state_q == StRmwRd) word_q <= ReadData;
    end
  end

endmodule
